frame_rx_modul: RTL

- Upstream stage of filtre_modul: consumes the raw byte stream from uart_modul (rx_data/rx_dvalid).
- Hunts for a 2-byte sync header, then forwards exactly row_depth*column_depth pixel bytes to the filter, tagged with row/column position and frame markers.
- A gap timer aborts a stalled frame so a lost byte never desynchronises the pipeline permanently.

---
 rtl/frame_rx_modul_pkg.sv | 27 ++
 rtl/frame_rx_modul_gap_timer.sv | 55 +++++
 rtl/frame_rx_modul.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_rx_modul_pkg.sv
// ---------------------------------------------------------------------------
// frame_rx_pkg
//   Shared types and constants for the frame receiver (and, later, the
//   matching transmit side).
//
//   state_e   : receiver FSM state (IDLE / SYNC / PAYLOAD)
//   SYNC0     : first header byte  (8'hA5)
//   SYNC1     : second header byte (8'h5A)
//   cntWidth  : width of a counter that indexes 0..depth-1, never below 1 bit
// ---------------------------------------------------------------------------
package frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  // A depth of 1 would give $clog2 == 0, which is not a legal vector width.
  function automatic int unsigned cntWidth(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frame_rx_modul_gap_timer.sv
// ---------------------------------------------------------------------------
// gap_timer
//   Saturating idle-gap counter. Counts clocks while enabled and flags the
//   update on which the count reaches TIMEOUT_CYCLES. Shared by the RX and
//   TX framing blocks.
//
//   i_clk     : system clock, rising edge
//   reset     : asynchronous, active-low reset
//   i_clr     : clear the count to zero (wins over counting)
//   i_en      : count this cycle
//   o_expired : high on the cycle whose clock edge brings the count to
//               TIMEOUT_CYCLES (combinational, qualified by i_en and ~i_clr)
// ---------------------------------------------------------------------------
module gap_timer #(
  parameter  int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter parks at LIMIT instead of wrapping, so a long idle period
  // can never roll over into a value that looks like fresh activity.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag the expiry on the edge that would take the count to LIMIT, so the
  // consumer can register its reaction on that same edge. A clear in the
  // same cycle suppresses it: fresh activity beats the timeout.
  assign o_expired = i_en && !i_clr && (cnt_q >= LIMIT_M1);

endmodule

// File: rtl/frame_rx_modul.sv
// ---------------------------------------------------------------------------
// frame_rx_modul
//   Sits between uart_modul and filtre_modul. Hunts for the A5 5A header in
//   the raw byte stream, then forwards exactly row_depth*column_depth pixel
//   bytes tagged with their row/column and frame markers. A gap timer drops
//   a stalled frame so a lost byte cannot desynchronise the pipeline.
//
//   Parameters
//     clk_speed      : system clock in Hz (documents TIMEOUT_CYCLES)
//     D_BITS         : byte width
//     row_depth      : rows per frame
//     column_depth   : pixels per row
//     TIMEOUT_CYCLES : max idle clocks between bytes before abort
//
//   Ports
//     i_clk     : system clock, rising edge
//     reset     : asynchronous, active-low reset
//     i_data    : received byte from UART
//     i_drdy    : one-cycle strobe, i_data valid
//     o_data    : pixel byte to filter
//     o_dvalid  : one-cycle strobe, o_data and tags valid
//     o_row     : row index of o_data
//     o_col     : column index of o_data
//     o_sof     : first pixel of the frame (row 0, col 0)
//     o_eol     : last pixel of a row
//     o_eof     : last pixel of the frame
//     o_busy    : receiver is in SYNC or PAYLOAD
//     o_timeout : one-cycle pulse when a payload is aborted by the gap timer
// ---------------------------------------------------------------------------
module frame_rx_modul
  import frame_rx_pkg::*;
#(
  parameter  int unsigned clk_speed      = 100_000000,
  parameter  int unsigned D_BITS         = 8,
  parameter  int unsigned row_depth      = 450,
  parameter  int unsigned column_depth   = 500,
  parameter  int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned ROW_W          = cntWidth(row_depth),
  localparam int unsigned COL_W          = cntWidth(column_depth)
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [D_BITS-1:0] i_data,
  input  logic              i_drdy,
  output logic [D_BITS-1:0] o_data,
  output logic              o_dvalid,
  output logic [ROW_W-1:0]  o_row,
  output logic [COL_W-1:0]  o_col,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof,
  output logic              o_busy,
  output logic              o_timeout
);

  // A zero clock or timeout would make the gap timer meaningless.
  if (clk_speed == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("frame_rx_modul: clk_speed and TIMEOUT_CYCLES must be non-zero");
  end

  localparam logic [D_BITS-1:0] HDR0     = D_BITS'(SYNC0);
  localparam logic [D_BITS-1:0] HDR1     = D_BITS'(SYNC1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(row_depth - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(column_depth - 1);

  // FSM state and position counters for the byte that arrives next.
  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;

  // Registered output stage.
  logic [D_BITS-1:0] data_q, data_d;
  logic [ROW_W-1:0]  orow_q, orow_d;
  logic [COL_W-1:0]  ocol_q, ocol_d;
  logic              dvalid_q, dvalid_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic              timeout_q, timeout_d;

  logic              gapClr;
  logic              gapEn;
  logic              gapExpired;
  logic              colLast;
  logic              rowLast;

  // The timer only runs while a header or payload is in progress. Holding
  // it clear in IDLE means every entry into SYNC/PAYLOAD starts from zero,
  // and every accepted byte restarts the gap measurement.
  assign gapEn  = (state_q != IDLE);
  assign gapClr = i_drdy || (state_q == IDLE);

  gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .i_clk     (i_clk),
    .reset     (reset),
    .i_clr     (gapClr),
    .i_en      (gapEn),
    .o_expired (gapExpired)
  );

  assign colLast = (col_q == COL_LAST);
  assign rowLast = (row_q == ROW_LAST);

  // Next-state and output-stage logic. Strobes default low every cycle so
  // they are single-cycle pulses; tag/data registers hold their last value.
  // In SYNC a repeated A5 keeps hunting, so A5 A5 5A is still a header.
  // A byte arriving on the expiry cycle is checked first and therefore
  // always beats the timeout.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    data_d    = data_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    dvalid_d  = 1'b0;
    sof_d     = 1'b0;
    eol_d     = 1'b0;
    eof_d     = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_drdy && (i_data == HDR0)) begin
          state_d = SYNC;
        end
      end

      SYNC: begin
        if (i_drdy) begin
          if (i_data == HDR1) begin
            state_d = PAYLOAD;
            row_d   = '0;
            col_d   = '0;
          end else if (i_data != HDR0) begin
            state_d = IDLE;
          end
        end else if (gapExpired) begin
          state_d = IDLE;
        end
      end

      PAYLOAD: begin
        if (i_drdy) begin
          data_d   = i_data;
          orow_d   = row_q;
          ocol_d   = col_q;
          dvalid_d = 1'b1;
          sof_d    = (row_q == '0) && (col_q == '0);
          eol_d    = colLast;
          eof_d    = colLast && rowLast;
          if (colLast) begin
            col_d = '0;
            if (rowLast) begin
              row_d   = '0;
              state_d = IDLE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end else if (gapExpired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          row_d     = '0;
          col_d     = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      data_q    <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      dvalid_q  <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      data_q    <= data_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      dvalid_q  <= dvalid_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_data    = data_q;
  assign o_dvalid  = dvalid_q;
  assign o_row     = orow_q;
  assign o_col     = ocol_q;
  assign o_sof     = sof_q;
  assign o_eol     = eol_q;
  assign o_eof     = eof_q;
  assign o_timeout = timeout_q;
  assign o_busy    = (state_q != IDLE);

endmodule
